// File: rtl/ser_pkg.sv
// Shared types and constants for the serializer transmitter.
package ser_pkg;
   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;
endpackage

// File: rtl/serializer_tx_if.sv
// Load handshake and serial output bundle for serializer_tx.
interface serializer_tx_if import ser_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) ();
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] d;
   logic             sout;
   logic             sframe;
   logic             done;

   modport master (output load_valid, d, input load_ready, sout, sframe, done);
   modport slave  (input load_valid, d, output load_ready, sout, sframe, done);
endinterface

// File: rtl/ff_ar_en.sv
// Enabled register with asynchronous active-high clear.
module ff_ar_en #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= '0;
      else if (en) q <= d;
   end
endmodule

// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter, one bit per cycle after a load handshake.
// Define SERIALIZER_TX_PARITY_EN to append an even-parity bit to each frame.
module serializer_tx import ser_pkg::*; #(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic            clk,
   input logic            reset,
   serializer_tx_if.slave bus
);
`ifdef SERIALIZER_TX_PARITY_EN
   localparam int FLEN = WIDTH + 1;
`else
   localparam int FLEN = WIDTH;
`endif
   localparam int            CW   = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_done;
   logic [FLEN-1:0] r_sr;
   logic            w_xfer;
   logic            w_en;
   logic [FLEN-1:0] w_frame;
   logic [FLEN-1:0] w_shift;
   logic [FLEN-1:0] w_sr_d;

   assign bus.load_ready = (r_state == IDLE) && !reset;
   assign w_xfer         = bus.load_valid && bus.load_ready;
   assign w_en           = w_xfer || (r_state == SHIFT);

   // The whole frame (parity included) is loaded at once; zeros shift in behind
   // it, so the register is empty again by the time the frame ends.
   always_comb begin
      w_frame = '0;
      w_shift = '0;
`ifdef SERIALIZER_TX_PARITY_EN
      if (MSB_FIRST) w_frame = {bus.d, ^bus.d};
      else           w_frame = {^bus.d, bus.d};
`else
      w_frame = bus.d;
`endif
      if (MSB_FIRST) w_shift = {r_sr[FLEN-2:0], 1'b0};
      else           w_shift = {1'b0, r_sr[FLEN-1:1]};
   end

   assign w_sr_d = w_xfer ? w_frame : w_shift;

   ff_ar_en #(.W(FLEN)) u_sr (
      .clk (clk),
      .rst (reset),
      .en  (w_en),
      .d   (w_sr_d),
      .q   (r_sr)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (w_xfer) begin
                  r_state <= SHIFT;
                  r_cnt   <= '0;
               end
            end
            SHIFT: begin
               if (r_cnt == LAST) begin
                  r_state <= IDLE;
                  r_done  <= 1'b0;
               end else begin
                  r_cnt  <= r_cnt + CW'(1);
                  r_done <= ((r_cnt + CW'(1)) == LAST);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.sout   = MSB_FIRST ? r_sr[FLEN-1] : r_sr[0];
   assign bus.sframe = (r_state == SHIFT);
   assign bus.done   = r_done;
endmodule

// File: doc/serializer_tx.md
SERIALIZER_TX -- requirements
Module: serializer_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4: parallel word width in bits, minimum 2.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 shifts the MSB out first, 0 shifts the LSB out first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port load_valid, input, 1 bit: the producer offers the word on d.
REQ-006 SHALL have port load_ready, output, 1 bit: the block can accept a word.
REQ-007 SHALL have port d, input, WIDTH bits: the parallel word.
REQ-008 SHALL have port sout, output, 1 bit: the serial data bit.
REQ-009 SHALL have port sframe, output, 1 bit: sout carries a valid frame bit.
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse marking the last bit of a frame.

Function
REQ-011 SHALL implement the states IDLE and SHIFT.
REQ-012 In IDLE: load_ready=1, sframe=0, sout=0 and done=0.
REQ-013 Transfer SHALL occur on a rising edge with load_valid&&load_ready: capture d, clear the bit counter, move to SHIFT.
REQ-014 Latency: the first bit SHALL appear on sout in the cycle right after the accepting edge; outputs are registered, with no combinational path from d to sout.
REQ-015 In SHIFT: sframe=1 and load_ready=0; sout SHALL present one bit per cycle in the order set by MSB_FIRST.
REQ-016 Frame length SHALL be WIDTH bits, or WIDTH+1 with parity (REQ-025).
REQ-017 done=1 only during the final bit cycle of a frame; the next edge SHALL return to IDLE.
REQ-018 load_valid and d changes during SHIFT SHALL be ignored: the captured word is not altered.
REQ-019 Back-to-back frames SHALL be separated by exactly one IDLE cycle while load_valid is held high.
REQ-020 Bit counter width SHALL be $clog2(WIDTH+2); the counter SHALL NOT wrap within a frame.

Reset
REQ-021 While reset=1, outputs SHALL immediately be: sout=0, sframe=0, done=0, load_ready=0, state=IDLE, shift register='0, counter=0.
REQ-022 Reset mid-frame SHALL abort the frame with no done pulse; the partial word SHALL be discarded.
REQ-023 Reset deassertion: load_ready=1 in the first cycle after reset; the first accepting edge is the first rising edge with reset=0.

Configuration
REQ-024 Without SERIALIZER_TX_PARITY_EN defined: frame = WIDTH data bits only.
REQ-025 With SERIALIZER_TX_PARITY_EN defined: an even-parity bit (XOR of the captured word) SHALL follow the last data bit, with sframe=1 and done asserted on that parity cycle instead.

Structure
REQ-026 Package ser_pkg SHALL hold the state enum (IDLE, SHIFT) and the constant DEFAULT_WIDTH=4.
REQ-027 The shift register SHALL be an instance of ff_ar_en: en=transfer|shift, and d muxed between the parallel word and the shifted value.

Verification (WIDTH=4 unless stated)
REQ-028 Reset: reset=1 with load_valid=1, d=4'b0110 -> sout=0, sframe=0, done=0, load_ready=0; after release, load_ready=1.
REQ-029 Basic MSB_FIRST=1 case: d=4'b0110 accepted -> sout 0,1,1,0 over 4 cycles, sframe high for 4 cycles, done high in cycle 4 only, then IDLE.
REQ-030 Mid-frame change: d changed to 4'b1100 with load_valid held during the frame -> first frame unchanged; 4'b1100 sent as 1,1,0,0 after one idle cycle.
REQ-031 Reset mid-frame: reset pulsed during the 2nd bit -> sout and sframe 0 at once, no done pulse; a new frame 4'b1001 sends correctly afterwards.
REQ-032 LSB-first case: MSB_FIRST=0, d=4'b0011 -> sout 1,1,0,0.
REQ-033 Parity case: SERIALIZER_TX_PARITY_EN defined, d=4'b1011 -> sout 1,0,1,1,1, sframe high for 5 cycles, done in cycle 5.
